// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-step shift-add multiply / restoring divide owning HI/LO.
// Signed ops run on magnitudes; signs are reapplied in the single FIX cycle.
module muldiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [2:0]  state_out
);
    localparam logic [2:0] S_IDLE = 3'd0, S_MULT = 3'd1, S_DIV = 3'd2, S_FIX = 3'd3, S_DONE = 3'd4;
    logic [2:0]  state, state_nx;
    logic [31:0] dsor, rem, acc_lo, mag_a, mag_b, trial;
    logic [5:0]  cnt;
    logic        is_div, sign_q, sign_r, dz, sgn, fit;
    logic [32:0] sum, sh_r;
    logic [63:0] prod, res;
    assign sgn   = ~op[0];
    assign mag_a = (sgn && a[31]) ? -a : a;
    assign mag_b = (sgn && b[31]) ? -b : b;
    assign sum   = {1'b0, rem} + (acc_lo[0] ? {1'b0, dsor} : 33'd0);
    // sh_r is the 33-bit shifted remainder; trial fits 32 bits whenever it is kept
    assign sh_r  = {rem, acc_lo[31]};
    assign fit   = sh_r >= {1'b0, dsor};
    assign trial = sh_r[31:0] - dsor;
    assign prod  = {rem, acc_lo};
    assign res   = is_div ? {sign_r ? -rem : rem, sign_q ? -acc_lo : acc_lo}
                          : (sign_q ? -prod : prod);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       state_nx = !start ? S_IDLE : !op[1] ? S_MULT : (b == 32'd0) ? S_DONE : S_DIV;
            S_MULT, S_DIV: state_nx = abort ? S_IDLE : (cnt == 6'd31) ? S_FIX : state;
            S_FIX:        state_nx = abort ? S_IDLE : S_DONE;
            default:      state_nx = S_IDLE;
        endcase
    end
    always_comb begin
        busy      = state != S_IDLE;
        done      = state == S_DONE;
        div_zero  = (state == S_DONE) && dz;
        state_out = state;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dsor   <= '0;
            rem    <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                dsor   <= op[1] ? mag_b : mag_a;
                acc_lo <= op[1] ? mag_a : mag_b;
                rem    <= '0;
                cnt    <= '0;
                is_div <= op[1];
                sign_q <= sgn & (a[31] ^ b[31]);
                sign_r <= sgn & a[31];
                dz     <= op[1] && (b == 32'd0);
            end
        end else if (!abort) begin
            if (state == S_MULT) begin
                rem    <= sum[32:1];
                acc_lo <= {sum[0], acc_lo[31:1]};
                cnt    <= cnt + 6'd1;
            end else if (state == S_DIV) begin
                rem    <= fit ? trial : sh_r[31:0];
                acc_lo <= {acc_lo[30:0], fit};
                cnt    <= cnt + 6'd1;
            end else if (state == S_FIX) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random ops checked against a plain-arithmetic
// model of MULT/MULTU/DIV/DIVU, including handshake timing, abort and reset.
module tb_muldiv_sequencer;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    logic [2:0]  state_out;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    int checks = 0, errors = 0;

    muldiv_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo), .state_out(state_out)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, m;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: r = sx * sy;
            2'd1: r = {32'd0, x} * {32'd0, y};
            2'd2: begin q = sx / sy; m = sx % sy; r = {m[31:0], q[31:0]}; end
            default: r = {x % y, x / y};
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit inject);
        logic [63:0] want;
        bit dzx, moved;
        int n;
        dzx  = o[1] && (y == 32'd0);
        want = dzx ? {exp_hi, exp_lo} : model(o, x, y);
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("busy_after_accept", busy, 1);
        n = 0;
        moved = 0;
        while (!done && n < 100) begin
            start = inject && (n == 4 || n == 32);
            @(posedge clock);
            #1 n++;
            if (!done && (hi !== exp_hi || lo !== exp_lo)) moved = 1;
        end
        start = 1'b0;
        chk("done_latency", n, dzx ? 0 : 33);
        chk("hilo_stable_while_busy", moved, 0);
        chk("div_zero", div_zero, dzx);
        chk("hi", hi, want[63:32]);
        chk("lo", lo, want[31:0]);
        @(posedge clock);
        #1 chk("idle_after_done", {busy, done, div_zero, state_out}, 0);
        exp_hi = want[63:32];
        exp_lo = want[31:0];
    endtask

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        repeat (2) @(posedge clock);
        #1 chk("reset_state", {busy, done, div_zero, state_out, hi, lo}, 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1 chk("idle_after_release", {busy, done, state_out}, 0);

        run_op(2'd0, 32'hFFFFFFFD, 32'd5, 0);
        chk("mult_neg3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0);
        chk("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'd3, 32'd7, 32'd2, 0);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("div_min_neg1", {hi, lo}, 64'h00000000_80000000);
        run_op(2'd1, 32'h22222222, 32'h80000001, 0);
        chk("preload", {hi, lo}, 64'h11111111_22222222);
        run_op(2'd3, 32'd7, 32'd0, 0);
        run_op(2'd2, 32'h12345678, 32'd0, 0);
        run_op(2'd0, 32'h00012345, 32'hFFFF0001, 1);

        @(negedge clock);
        op = 2'd0; a = 32'd100; b = 32'd200; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (n = 1; n < 10; n++) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        chk("abort_idle", {busy, done, state_out}, 0);
        chk("abort_hilo", {hi, lo}, {exp_hi, exp_lo});
        n = 0;
        repeat (40) begin @(posedge clock); #1 if (done || busy) n++; end
        chk("abort_no_done", n, 0);

        @(negedge clock);
        op = 2'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (n = 1; n < 20; n++) @(posedge clock);
        #3 reset = 1'b1;
        #1 chk("async_reset", {busy, done, state_out, hi, lo}, 0);
        @(negedge clock) reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        run_op(2'd0, 32'd6, 32'd7, 0);
        chk("mult_6x7", {hi, lo}, 64'd42);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h80000000;
                default: ;
            endcase
            run_op(ro, ra, rb, i % 5 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
